plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter.sv | 157 +++++++++++++++
 tb/tb_plot_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// plot_arbiter -- shares one VGA pixel-write port among four requesters
// (0 loader, 1 ball, 2 brick, 3 platform).
//
// The arbiter picks a winner in IDLE and holds it for a whole burst in GRANT.
// During the burst it registers the winner's pixel onto x/y/colour/plot.
// It then spends one RELEASE cycle with no grant before it arbitrates again.
//
// Optional macro PLOT_RR_EN selects the arbitration policy:
//   - defined:   round-robin arbitration.
//   - undefined: fixed priority, index 0 highest.
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   req[3:0]             per-requester access request
//   done[3:0]            per-requester end-of-burst strobe
//   x_in, y_in[39:0]     packed 10-bit coordinates, requester i at [10i+9:10i]
//   colour_in[11:0]      packed 3-bit colours, requester i at [3i+2:3i]
//   we_in[3:0]           per-requester pixel write strobe
//   gnt[3:0]             registered one-hot grant, 0 when nobody is granted
//   x, y, colour, plot   registered pixel write to the VGA adapter
//   busy                 state is not IDLE
//   timeout_flag         sticky; set when a burst is cut off by the timeout
module plot_arbiter #(
    parameter int MAX_X   = 159,
    parameter int MAX_Y   = 119,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [39:0] x_in,
    input  logic [39:0] y_in,
    input  logic [11:0] colour_in,
    input  logic [3:0]  we_in,
    output logic [3:0]  gnt,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        timeout_flag
);
    localparam logic [9:0] MX = MAX_X[9:0];
    localparam logic [9:0] MY = MAX_Y[9:0];
    localparam logic [9:0] TO = TIMEOUT[9:0];

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t     state;
    logic [1:0] win;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic [9:0] cnt;
    logic [9:0] cnt_nxt;
    logic [9:0] wx;
    logic [9:0] wy;
    logic [2:0] wc;
    logic       in_range;
`ifdef PLOT_RR_EN
    logic [1:0] ptr;
`endif

    // The first requester found wins.
    // Round-robin searches upward from the pointer; fixed priority searches upward from 0.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef PLOT_RR_EN
            idx = ptr + 2'(i);
`else
            idx = 2'(i);
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // The winner's slice is the only one that ever reaches the outputs.
    always_comb begin
        wx = '0;
        wy = '0;
        wc = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                wx = x_in[10*i +: 10];
                wy = y_in[10*i +: 10];
                wc = colour_in[3*i +: 3];
            end
        end
    end

    assign in_range = (wx <= MX) && (wy <= MY);
    assign cnt_nxt  = cnt + 10'd1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            gnt          <= '0;
            win          <= '0;
            cnt          <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            timeout_flag <= 1'b0;
`ifdef PLOT_RR_EN
            ptr          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    gnt  <= '0;
                    if (found) begin
                        gnt   <= 4'b0001 << pick;
                        win   <= pick;
                        cnt   <= '0;
                        state <= GRANT;
`ifdef PLOT_RR_EN
                        ptr   <= pick + 2'd1;
`endif
                    end
                end
                GRANT: begin
                    // The pixel is forwarded even on the last cycle of a burst,
                    // so a write that coincides with done still lands.
                    x      <= wx;
                    y      <= wy;
                    colour <= wc;
                    plot   <= we_in[win] && in_range;
                    cnt    <= cnt_nxt;
                    if (done[win] || !req[win]) begin
                        gnt   <= '0;
                        state <= RELEASE;
                    end else if (cnt_nxt == TO) begin
                        gnt          <= '0;
                        timeout_flag <= 1'b1;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    plot  <= 1'b0;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (TIMEOUT overridden to 8).
module tb_plot_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req, done, we_in;
    logic [39:0] x_in, y_in;
    logic [11:0] colour_in;
    logic [3:0]  gnt;
    logic [9:0]  x, y;
    logic [2:0]  colour;
    logic        plot, busy, timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;

    plot_arbiter #(.MAX_X(159), .MAX_Y(119), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .we_in(we_in),
        .gnt(gnt), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setpix(input int i, input logic [9:0] px, input logic [9:0] py,
                          input logic [2:0] c, input logic w);
        x_in[10*i +: 10]    = px;
        y_in[10*i +: 10]    = py;
        colour_in[3*i +: 3] = c;
        we_in[i]            = w;
    endtask

    logic [3:0] exp_gnt [5];

    initial begin
        resetn = 1'b0; req = '0; done = '0; we_in = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        step(); step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_plot", 32'(plot), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flag", 32'(timeout_flag), 32'h0);
        check("rst_xyc", {x, y, 9'd0, colour}, 32'h0);
        resetn = 1'b1;
        step();
        check("idle_noreq_gnt", 32'(gnt), 32'h0);

        // Contention: all four requesters hold req; each burst ends with done after 2 cycles.
`ifdef PLOT_RR_EN
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            step();
            check($sformatf("cont_gnt%0d", r), 32'(gnt), 32'(exp_gnt[r]));
            step();
            done = exp_gnt[r];
            step();
            check($sformatf("cont_rel%0d", r), 32'(gnt), 32'h0);
            done = '0;
            step();
        end
        req = '0;
        step();
        check("cont_idle_busy", 32'(busy), 32'h0);

        // Single request: three pixels at (5,7) from requester 1.
        req = 4'b0010;
        step();
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        check("single_plot0", 32'(plot), 32'h0);
        setpix(1, 10'd5, 10'd7, 3'b100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("single_plot%0d", k + 1), 32'(plot), 32'h1);
            check($sformatf("single_xyc%0d", k + 1), {x, y, 9'd0, colour},
                  {10'd5, 10'd7, 9'd0, 3'b100});
        end
        setpix(1, 10'd5, 10'd7, 3'b100, 1'b0);
        done = 4'b0010;
        step();
        check("single_rel_gnt", 32'(gnt), 32'h0);
        check("single_rel_plot", 32'(plot), 32'h0);
        check("single_rel_busy", 32'(busy), 32'h1);
        done = '0; req = '0;
        step();
        check("single_idle_busy", 32'(busy), 32'h0);

        // Clipping on requester 0; requester 3 writes noise without being granted.
        req = 4'b0001;
        step();
        check("clip_gnt", 32'(gnt), 32'h1);
        setpix(3, 10'd42, 10'd3, 3'b111, 1'b1);
        setpix(0, 10'd160, 10'd10, 3'b001, 1'b1);
        step();
        check("clip_x160_plot", 32'(plot), 32'h0);
        check("clip_x160_x", 32'(x), 32'd160);
        setpix(0, 10'd10, 10'd120, 3'b010, 1'b1);
        step();
        check("clip_y120_plot", 32'(plot), 32'h0);
        check("clip_y120_y", 32'(y), 32'd120);
        setpix(0, 10'd159, 10'd119, 3'b011, 1'b1);
        step();
        check("clip_edge_plot", 32'(plot), 32'h1);
        check("clip_edge_xyc", {x, y, 9'd0, colour}, {10'd159, 10'd119, 9'd0, 3'b011});
        // A write coinciding with done is still forwarded.
        setpix(0, 10'd20, 10'd30, 3'b101, 1'b1);
        done = 4'b0001;
        step();
        check("clip_done_plot", 32'(plot), 32'h1);
        check("clip_done_x", 32'(x), 32'd20);
        check("clip_done_gnt", 32'(gnt), 32'h0);
        setpix(0, 10'd0, 10'd0, 3'b000, 1'b0);
        setpix(3, 10'd0, 10'd0, 3'b000, 1'b0);
        done = '0; req = '0;
        step();
        check("clip_rel_plot", 32'(plot), 32'h0);

        // Timeout: requester 2 never signals done.
        req = 4'b0100;
        step();
        check("to_gnt", 32'(gnt), 32'h4);
        for (int k = 0; k < 7; k++) step();
        check("to_still_gnt", 32'(gnt), 32'h4);
        check("to_flag_pre", 32'(timeout_flag), 32'h0);
        step();
        check("to_rel_gnt", 32'(gnt), 32'h0);
        check("to_flag", 32'(timeout_flag), 32'h1);
        req = '0;
        step();
        check("to_idle_busy", 32'(busy), 32'h0);
        check("to_flag_sticky", 32'(timeout_flag), 32'h1);

        // Dropped request: req[1] falls mid-burst while req[2] waits.
        req = 4'b0010;
        step();
        check("drop_gnt1", 32'(gnt), 32'h2);
        req = 4'b0110;
        step();
        check("drop_hold", 32'(gnt), 32'h2);
        req = 4'b0100;
        step();
        check("drop_rel", 32'(gnt), 32'h0);
        check("drop_rel_busy", 32'(busy), 32'h1);
        step();
        check("drop_idle", 32'(gnt), 32'h0);
        step();
        check("drop_gnt2", 32'(gnt), 32'h4);
        done = 4'b0100;
        step();
        done = '0; req = '0;
        step();

        // Reset in the middle of requester 3's burst.
        req = 4'b1000;
        step();
        check("mid_gnt", 32'(gnt), 32'h8);
        setpix(3, 10'd1, 10'd1, 3'b110, 1'b1);
        step();
        check("mid_plot", 32'(plot), 32'h1);
        resetn = 1'b0;
        step();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_plot", 32'(plot), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_flag", 32'(timeout_flag), 32'h0);
        check("mid_rst_xyc", {x, y, 9'd0, colour}, 32'h0);
        resetn = 1'b1; req = '0;
        setpix(3, 10'd0, 10'd0, 3'b000, 1'b0);
        step();
        check("mid_after_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
